// File: rtl/iob_native_mem_model_if.sv
// rtl/iob_native_mem_model_if.sv - native-interface request/response bus
// Groups the handshake and data signals between a native master and the memory model.
interface iob_native_mem_model_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic                  valid;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic [DATA_W-1:0]     rdata;
  logic                  ready;

  modport master (output valid, addr, wdata, wstrb, input rdata, ready);
  modport slave  (input valid, addr, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/iob_native_mem_model.sv
// rtl/iob_native_mem_model.sv - byte-writable native backing memory with programmable latency
// Fixed or LFSR-stalled response latency, saturating transaction counters and a sticky protocol flag.
module iob_native_mem_model #(
  parameter int          DATA_W     = 32,
  parameter int          ADDR_W     = 10,
  parameter int          LATENCY    = 1,
  parameter int          STALL_MODE = 0,
  parameter int          STALL_W    = 2,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  iob_native_mem_model_if.slave bus,
  output logic [CNT_W-1:0]      rd_cnt,
  output logic [CNT_W-1:0]      wr_cnt,
  output logic                  err
);
  localparam int STRB_W = DATA_W / 8;
  localparam int CW     = 5 + STALL_W;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [15:0]       lfsr;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [DATA_W-1:0] rdata_q;
  logic              ready_q;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic [15:0]       lfsr_next;
  logic [CW-1:0]     load;
  logic              commit;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic [STRB_W-1:0] c_wstrb;

  // A zero-length wait commits straight from IDLE, so the commit path muxes live bus vs latched fields.
  always_comb begin
    lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    load      = CW'(LATENCY - 1);
    if (STALL_MODE == 1) load = load + CW'(lfsr[STALL_W-1:0]);
    commit  = ((state == IDLE) && bus.valid && (load == '0)) ||
              ((state == WAIT) && (cnt == CW'(1)));
    c_addr  = (state == IDLE) ? bus.addr  : addr_q;
    c_wdata = (state == IDLE) ? bus.wdata : wdata_q;
    c_wstrb = (state == IDLE) ? bus.wstrb : wstrb_q;
  end

  always_ff @(posedge clk) begin
    if (commit && !reset) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (c_wstrb[i]) mem[c_addr][i*8 +: 8] <= c_wdata[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      lfsr    <= LFSR_SEED;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      err     <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.valid) begin
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            wstrb_q <= bus.wstrb;
            lfsr    <= lfsr_next;
            cnt     <= load;
            state   <= (load == '0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (!bus.valid || (bus.addr != addr_q) || (bus.wstrb != wstrb_q)) err <= 1'b1;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (commit) begin
        ready_q <= 1'b1;
        if (c_wstrb == '0) begin
          rdata_q <= mem[c_addr];
          if (rd_cnt != '1) rd_cnt <= rd_cnt + CNT_W'(1);
        end else begin
          if (wr_cnt != '1) wr_cnt <= wr_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = ready_q;
endmodule

// File: tb/tb_iob_native_mem_model.sv
// tb/tb_iob_native_mem_model.sv - directed bench for iob_native_mem_model
// Four instances: LATENCY=1, LATENCY=4, LATENCY=1 with LFSR stalls, LATENCY=3.
module tb_iob_native_mem_model;
  localparam logic [15:0] LATS = {4'd3, 4'd1, 4'd4, 4'd1};
  localparam logic [3:0]  SMS  = 4'b0100;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        valid_v [4];
  logic [9:0]  addr_v  [4];
  logic [31:0] wdata_v [4];
  logic [3:0]  wstrb_v [4];
  logic [31:0] rdata_v [4];
  logic        ready_v [4];
  logic [31:0] rd_cnt_v [4];
  logic [31:0] wr_cnt_v [4];
  logic        err_v   [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    iob_native_mem_model_if #(.DATA_W(32), .ADDR_W(10)) bus ();
    iob_native_mem_model #(
      .DATA_W(32), .ADDR_W(10), .LATENCY(int'(LATS[g*4 +: 4])),
      .STALL_MODE(int'(SMS[g])), .STALL_W(2), .LFSR_SEED(SEED), .CNT_W(32)
    ) dut (
      .clk(clk), .reset(reset), .bus(bus),
      .rd_cnt(rd_cnt_v[g]), .wr_cnt(wr_cnt_v[g]), .err(err_v[g])
    );
    assign bus.valid  = valid_v[g];
    assign bus.addr   = addr_v[g];
    assign bus.wdata  = wdata_v[g];
    assign bus.wstrb  = wstrb_v[g];
    assign rdata_v[g] = bus.rdata;
    assign ready_v[g] = bus.ready;
  end

  initial begin
    for (int i = 0; i < 4; i++)
      if (LATS[i*4 +: 4] == 4'd0) $error("configuration error: LATENCY=0 on instance %0d", i);
    if (SEED == 16'h0) $error("configuration error: LFSR_SEED=0");
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Drives one request, measures cycles from valid rising to ready, then confirms ready is one cycle wide.
  task automatic req(input int sel, input logic [9:0] a, input logic [31:0] wd,
                     input logic [3:0] ws, input bit hold,
                     output int lat, output logic [31:0] rd);
    valid_v[sel] = 1'b1; addr_v[sel] = a; wdata_v[sel] = wd; wstrb_v[sel] = ws;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!ready_v[sel] && lat < 40);
    rd = rdata_v[sel];
    if (!ready_v[sel]) chk("ready_timeout", 32'(ready_v[sel]), 32'd1);
    if (!hold) valid_v[sel] = 1'b0;
    @(posedge clk); #1;
    valid_v[sel] = 1'b0;
    chk("ready_width", 32'(ready_v[sel]), 32'd0);
  endtask

  typedef struct {
    int          sel;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int lat;
    logic [31:0] rd;
    logic [15:0] lfsr_m;
    int highs;

    for (int i = 0; i < 4; i++) begin
      valid_v[i] = 1'b0; addr_v[i] = '0; wdata_v[i] = '0; wstrb_v[i] = '0;
    end

    for (int i = 1; i <= 9; i++)
      vecs.push_back('{0, 10'(i), 32'h10 + 32'(i), 4'hF, 32'h0, 1});
    for (int i = 1; i <= 9; i++)
      vecs.push_back('{0, 10'(i), 32'h0, 4'h0, 32'h10 + 32'(i), 1});
    vecs.push_back('{0, 10'd5, 32'hDEADBEEF, 4'hF, 32'h19, 1});
    vecs.push_back('{0, 10'd5, 32'h000000AA, 4'h1, 32'h19, 1});
    vecs.push_back('{0, 10'd5, 32'h0,        4'h0, 32'hDEADBEAA, 1});
    vecs.push_back('{1, 10'd2, 32'hCAFE0002, 4'hF, 32'h0, 4});
    vecs.push_back('{1, 10'd9, 32'h12345678, 4'hF, 32'h0, 4});
    vecs.push_back('{1, 10'd9, 32'h0,        4'h0, 32'h12345678, 4});
    vecs.push_back('{3, 10'd7, 32'h00000077, 4'hF, 32'h0, 3});
    vecs.push_back('{3, 10'd3, 32'h00000033, 4'hF, 32'h0, 3});

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("reset_ready", 32'(ready_v[i]), 32'd0);
      chk("reset_rdata", rdata_v[i], 32'd0);
      chk("reset_rd_cnt", rd_cnt_v[i], 32'd0);
      chk("reset_wr_cnt", wr_cnt_v[i], 32'd0);
      chk("reset_err", 32'(err_v[i]), 32'd0);
    end

    for (int k = 0; k < vecs.size(); k++) begin
      req(vecs[k].sel, vecs[k].addr, vecs[k].wdata, vecs[k].wstrb, 1'b0, lat, rd);
      chk($sformatf("vec%0d_latency", k), 32'(lat), 32'(vecs[k].exp_lat));
      chk($sformatf("vec%0d_rdata", k), rd, vecs[k].exp_rdata);
      if (k == 17) begin
        chk("fixed_wr_cnt", wr_cnt_v[0], 32'd9);
        chk("fixed_rd_cnt", rd_cnt_v[0], 32'd9);
      end
    end
    chk("strobe_wr_cnt", wr_cnt_v[0], 32'd11);
    chk("strobe_rd_cnt", rd_cnt_v[0], 32'd10);

    // Valid held through RESP must not start a second transaction.
    req(1, 10'd2, 32'h0, 4'h0, 1'b1, lat, rd);
    chk("hold_latency", 32'(lat), 32'd4);
    chk("hold_rdata", rd, 32'hCAFE0002);
    highs = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ready_v[1]) highs++;
    end
    chk("hold_no_second_ready", 32'(highs), 32'd0);
    chk("hold_rd_cnt", rd_cnt_v[1], 32'd2);

    lfsr_m = SEED;
    for (int k = 0; k < 16; k++) begin
      req(2, 10'(k), 32'h0, 4'h0, 1'b0, lat, rd);
      chk($sformatf("stall%0d_range", k), 32'(lat >= 1 && lat <= 4), 32'd1);
      chk($sformatf("stall%0d_latency", k), 32'(lat), 32'd1 + 32'(lfsr_m[1:0]));
      lfsr_m = {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
    end
    chk("stall_rd_cnt", rd_cnt_v[2], 32'd16);

    // Drop valid and move addr for one WAIT cycle; the latched address must still be served.
    valid_v[3] = 1'b1; addr_v[3] = 10'd7; wstrb_v[3] = 4'h0; wdata_v[3] = 32'h0;
    @(posedge clk); #1;
    chk("proto_err_before", 32'(err_v[3]), 32'd0);
    valid_v[3] = 1'b0; addr_v[3] = 10'd3;
    @(posedge clk); #1;
    chk("proto_err_set", 32'(err_v[3]), 32'd1);
    valid_v[3] = 1'b1; addr_v[3] = 10'd7;
    lat = 2;
    do begin
      @(posedge clk); #1; lat++;
    end while (!ready_v[3] && lat < 40);
    chk("proto_latency", 32'(lat), 32'd3);
    chk("proto_rdata", rdata_v[3], 32'h77);
    valid_v[3] = 1'b0;
    @(posedge clk); #1;
    chk("proto_err_sticky", 32'(err_v[3]), 32'd1);
    req(3, 10'd3, 32'h0, 4'h0, 1'b0, lat, rd);
    chk("proto_next_latency", 32'(lat), 32'd3);
    chk("proto_next_rdata", rd, 32'h33);
    chk("proto_err_still", 32'(err_v[3]), 32'd1);
    chk("proto_rd_cnt", rd_cnt_v[3], 32'd2);
    chk("proto_wr_cnt", wr_cnt_v[3], 32'd2);

    // Reset one cycle after accepting a LATENCY=4 write: the write must not land.
    valid_v[1] = 1'b1; addr_v[1] = 10'd9; wdata_v[1] = 32'hBADBAD00; wstrb_v[1] = 4'hF;
    @(posedge clk); #1;
    reset = 1'b1; valid_v[1] = 1'b0; wstrb_v[1] = 4'h0;
    #1;
    chk("rst_mid_ready", 32'(ready_v[1]), 32'd0);
    chk("rst_mid_rdata", rdata_v[1], 32'd0);
    chk("rst_mid_rd_cnt", rd_cnt_v[1], 32'd0);
    chk("rst_mid_wr_cnt", wr_cnt_v[1], 32'd0);
    chk("rst_mid_err", 32'(err_v[1]), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_hold_ready", 32'(ready_v[1]), 32'd0);
    end
    reset = 1'b0;
    req(1, 10'd9, 32'h0, 4'h0, 1'b0, lat, rd);
    chk("rst_read_latency", 32'(lat), 32'd4);
    chk("rst_read_old_value", rd, 32'h12345678);
    chk("rst_wr_cnt", wr_cnt_v[1], 32'd0);
    chk("rst_rd_cnt", rd_cnt_v[1], 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
